// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types used by the register-file subordinate and the manager.
// Response codes and the write/read channel FSM state encodings live here.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    W_IDLE      = 2'b00,
    W_HAVE_ADDR = 2'b01,
    W_HAVE_DATA = 2'b10,
    W_RESP      = 2'b11
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_reg_array.sv
// NUM_REGS x DATA_WIDTH register storage: one synchronous write port, one
// combinational read port that the owner samples, synchronous clear.
module axi_lite_reg_array #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 64,
  parameter int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i && (32'(waddr_i) < NUM_REGS)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Guard keeps non-power-of-two depths from indexing past the array.
  assign rdata_o = (32'(raddr_i) < NUM_REGS) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/axi_lite_subordinate_regfile.sv
// AXI4-Lite subordinate exposing NUM_REGS byte registers. Independent write
// (AW/W/B) and read (AR/R) FSMs; out-of-range accesses complete with SLVERR.
module axi_lite_subordinate_regfile
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 64
) (
  input  logic                  s_axi_clk,
  input  logic                  s_axi_reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic                  s_axi_wlast,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [1:0]            dbg_wr_state_o,
  output logic                  dbg_rd_state_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Handshake rule on every channel: a transfer happens at a rising edge
  // where valid && ready; ready/valid outputs come straight from flops.

  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;

  wr_state_t             wr_state_q, wr_state_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  axi_resp_t             bresp_q, bresp_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic                  commit, commit_ok;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;
  logic                  aw_hs, w_hs;

  assign aw_hs     = s_axi_awvalid && awready_q;
  assign w_hs      = s_axi_wvalid && wready_q;
  assign commit_ok = (32'(commit_addr) < NUM_REGS);

  always_comb begin
    wr_state_d  = wr_state_q;
    aw_addr_d   = aw_addr_q;
    w_data_d    = w_data_q;
    bresp_d     = bresp_q;
    commit      = 1'b0;
    commit_addr = aw_addr_q;
    commit_data = w_data_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          commit_addr = s_axi_awaddr;
          commit_data = s_axi_wdata;
        end else if (aw_hs) begin
          aw_addr_d  = s_axi_awaddr;
          wr_state_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_data_d   = s_axi_wdata;
          wr_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs) begin
          commit      = 1'b1;
          commit_data = s_axi_wdata;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs) begin
          commit      = 1'b1;
          commit_addr = s_axi_awaddr;
        end
      end
      W_RESP: begin
        if (s_axi_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (commit) begin
      wr_state_d = W_RESP;
      bresp_d    = commit_ok ? OKAY : SLVERR;
    end
  end

  // Readies are registered versions of what the next state will accept.
  assign awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_DATA);
  assign wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_ADDR);
  assign bvalid_d  = (wr_state_d == W_RESP);

  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) begin
      wr_state_q <= W_IDLE;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      bresp_q    <= OKAY;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      bresp_q    <= bresp_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
    end
  end

  rd_state_t             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  axi_resp_t             rresp_q, rresp_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ar_hs, rd_ok;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign ar_hs = s_axi_arvalid && arready_q;
  assign rd_ok = (32'(s_axi_araddr) < NUM_REGS);

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d    = rd_ok ? arr_rdata : '0;
          rresp_d    = rd_ok ? OKAY : SLVERR;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axi_rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign arready_d = (rd_state_d == R_IDLE);
  assign rvalid_d  = (rd_state_d == R_RESP);

  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Reading the array before the commit edge gives pre-write data on a
  // same-edge write/read collision.
  axi_lite_reg_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regs (
    .clk_i   (s_axi_clk),
    .rst_i   (s_axi_reset),
    .we_i    (commit && commit_ok),
    .waddr_i (commit_addr[IDX_W-1:0]),
    .wdata_i (commit_data),
    .raddr_i (s_axi_araddr[IDX_W-1:0]),
    .rdata_o (arr_rdata)
  );

  assign s_axi_awready  = awready_q;
  assign s_axi_wready   = wready_q;
  assign s_axi_bvalid   = bvalid_q;
  assign s_axi_bresp    = bresp_q;
  assign s_axi_arready  = arready_q;
  assign s_axi_rvalid   = rvalid_q;
  assign s_axi_rdata    = rdata_q;
  assign s_axi_rresp    = rresp_q;
  assign dbg_wr_state_o = wr_state_q;
  assign dbg_rd_state_o = rd_state_q;

endmodule
